// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand-bypass and load-use hazard unit for an in-order pipeline.
//
// A small tracker remembers the destination of every instruction that has
// left ID and is still in flight (T[0] = EX, T[1] = next stage, ...). Each
// source operand of the instruction in ID is compared against the tracker.
// The youngest matching producer supplies the bypass select that travels
// with the instruction into EX. A producer that is a load, and whose data
// is not yet available by the time the consumer reaches EX, forces a
// one-cycle stall. While stalled, the tracker keeps draining and a bubble
// is inserted behind it.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   id_valid     in   ID holds a real instruction
//   id_src_addr  in   NUM_SRC*REG_AW source addresses, src i at [i*REG_AW +: REG_AW]
//   id_src_used  in   NUM_SRC per-source "operand is read" flags
//   id_dst_addr  in   REG_AW destination register
//   id_dst_wr    in   instruction writes id_dst_addr
//   id_is_load   in   instruction is a memory read
//   flush        in   squash all in-flight instructions and ID
//   stall        out  hold PC/IF/ID this cycle (combinational)
//   ex_valid     out  EX holds a real instruction
//   ex_fwd_sel   out  NUM_SRC*SELW bypass selects for the instruction in EX
//                     (0 = register file, k+1 = output of stage k)
//   stall_cnt    out  CNT_W saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int LOAD_STG  = 2,
  parameter int ZERO_HARD = 0,
  parameter int CNT_W     = 16,
  localparam int SELW     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_dst_wr,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  // One in-flight producer record.
  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] dst;
  } trk_t;

  trk_t                    trk_reg [DEPTH];
  logic                    ex_valid_reg;
  logic [NUM_SRC*SELW-1:0] ex_fwd_sel_reg;
  logic [CNT_W-1:0]        stall_cnt_reg;

  logic [NUM_SRC*SELW-1:0] sel_next;
  logic [NUM_SRC-1:0]      src_haz;
  logic                    stall_int;

  // -------------------------------------------------------------------------
  // Per-source match and priority selection.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      logic [SELW-1:0]   sel;
      logic              haz;

      assign src = id_src_addr[gi*REG_AW +: REG_AW];

      // Walking from the oldest stage down to the youngest lets the youngest
      // match overwrite any older one, so no explicit "found" flag is needed.
      // Producers older than the tracked window are already in the register
      // file, so no match means select 0.
      always_comb begin
        sel = '0;
        haz = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (id_src_used[gi] && trk_reg[k].v && trk_reg[k].wr &&
              (trk_reg[k].dst == src) &&
              ((ZERO_HARD == 0) || (src != '0))) begin
            sel = SELW'(k + 1);
            // Load data first appears at the output of stage LOAD_STG-1,
            // i.e. select value LOAD_STG; anything younger is not ready.
            haz = trk_reg[k].ld && ((k + 1) < LOAD_STG);
          end
        end
      end

      assign sel_next[gi*SELW +: SELW] = sel;
      assign src_haz[gi]               = haz;
    end
  endgenerate

  // Flush beats the hazard; reset also masks it so stall is quiet while
  // rst_n is held regardless of what ID presents.
  assign stall_int = rst_n & id_valid & ~flush & (|src_haz);
  assign stall     = stall_int;

  // -------------------------------------------------------------------------
  // Tracker, EX stage registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        trk_reg[k] <= '0;
      end
      ex_valid_reg   <= 1'b0;
      ex_fwd_sel_reg <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        trk_reg[k] <= '0;
      end
      ex_valid_reg   <= 1'b0;
      ex_fwd_sel_reg <= '0;
    end else begin
      // The tracker drains every cycle, stalled or not: producers ahead of
      // the stalled instruction keep moving toward write-back.
      for (int k = DEPTH - 1; k > 0; k--) begin
        trk_reg[k] <= trk_reg[k-1];
      end
      if (stall_int) begin
        trk_reg[0]     <= '0;
        ex_valid_reg   <= 1'b0;
        ex_fwd_sel_reg <= '0;
      end else begin
        trk_reg[0].v   <= id_valid;
        trk_reg[0].wr  <= id_dst_wr;
        trk_reg[0].ld  <= id_is_load;
        trk_reg[0].dst <= id_dst_addr;
        ex_valid_reg   <= id_valid;
        ex_fwd_sel_reg <= sel_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating load-use stall counter; flush does not touch it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_fwd_sel = ex_fwd_sel_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Three instances share one set of ID inputs:
//   u0  default parameters        - table-driven vectors
//   u1  ZERO_HARD=1               - register-0 handling
//   u2  DEPTH=21 LOAD_STG=21 CNT_W=4 - long stall run, saturation, reset
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_src_addr;
  logic [1:0] id_src_used;
  logic [2:0] id_dst_addr;
  logic       id_dst_wr;
  logic       id_is_load;
  logic       flush;

  logic        stall0, exv0;
  logic [3:0]  sel0;
  logic [15:0] cnt0;
  logic        stall1, exv1;
  logic [3:0]  sel1;
  logic [15:0] cnt1;
  logic        stall2, exv2;
  logic [9:0]  sel2;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall0), .ex_valid(exv0),
    .ex_fwd_sel(sel0), .stall_cnt(cnt0)
  );

  fwd_hazard_unit #(.ZERO_HARD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall1), .ex_valid(exv1),
    .ex_fwd_sel(sel1), .stall_cnt(cnt1)
  );

  fwd_hazard_unit #(.DEPTH(21), .LOAD_STG(21), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall2), .ex_valid(exv2),
    .ex_fwd_sel(sel2), .stall_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  s1;
    logic [2:0]  s0;
    logic [1:0]  used;
    logic [2:0]  dst;
    logic        wr;
    logic        ld;
    logic        fl;
    logic        e_stall;
    logic        e_exv;
    logic [1:0]  e_sel1;
    logic [1:0]  e_sel0;
    logic        chk_sel;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t row(input int v, s1, s0, used, dst, wr, ld, fl,
                               es, ev, e1, e0, chk, ec);
    vec_t r;
    r.v = 1'(v);        r.s1 = 3'(s1);      r.s0 = 3'(s0);
    r.used = 2'(used);  r.dst = 3'(dst);    r.wr = 1'(wr);
    r.ld = 1'(ld);      r.fl = 1'(fl);      r.e_stall = 1'(es);
    r.e_exv = 1'(ev);   r.e_sel1 = 2'(e1);  r.e_sel0 = 2'(e0);
    r.chk_sel = 1'(chk); r.e_cnt = 16'(ec);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic [2:0] s0,
                       input logic [1:0] used, input logic [2:0] dst,
                       input logic wr, input logic ld, input logic fl);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_used = used;
    id_dst_addr = dst;
    id_dst_wr   = wr;
    id_is_load  = ld;
    flush       = fl;
  endtask

  initial begin
    //              v s1 s0 us dst wr ld fl | stall exv sel1 sel0 chk cnt
    tbl[0]  = row(1, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 1, 0); // ADD r1
    tbl[1]  = row(1, 0, 1, 1, 4, 1, 0, 0,   0, 1, 0, 1, 1, 0); // use r1 from EX
    tbl[2]  = row(1, 0, 0, 0, 2, 1, 1, 0,   0, 1, 0, 0, 1, 0); // LD r2
    tbl[3]  = row(1, 2, 0, 2, 5, 1, 0, 0,   1, 0, 0, 0, 1, 1); // load-use stall
    tbl[4]  = row(1, 2, 0, 2, 5, 1, 0, 0,   0, 1, 2, 0, 1, 1); // retry: sel1=2
    tbl[5]  = row(1, 0, 0, 0, 3, 1, 0, 0,   0, 1, 0, 0, 1, 1); // r3 (older)
    tbl[6]  = row(1, 0, 0, 0, 3, 1, 0, 0,   0, 1, 0, 0, 1, 1); // r3 (younger)
    tbl[7]  = row(1, 3, 3, 3, 0, 0, 0, 0,   0, 1, 1, 1, 1, 1); // both srcs r3
    tbl[8]  = row(1, 3, 3, 1, 0, 0, 0, 0,   0, 1, 0, 2, 1, 1); // src1 unused
    tbl[9]  = row(1, 0, 3, 1, 0, 0, 0, 0,   0, 1, 0, 3, 1, 1); // oldest stage
    tbl[10] = row(1, 0, 3, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1); // beyond depth
    tbl[11] = row(1, 0, 0, 0, 6, 1, 1, 0,   0, 1, 0, 0, 1, 1); // LD r6
    tbl[12] = row(0, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // invalid ID no stall
    tbl[13] = row(1, 0, 6, 1, 7, 0, 0, 0,   0, 1, 0, 2, 1, 1); // r6 at T[1]
    tbl[14] = row(1, 0, 0, 0, 7, 1, 1, 0,   0, 1, 0, 0, 1, 1); // LD r7
    tbl[15] = row(1, 0, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1); // flush kills stall
    tbl[16] = row(1, 0, 7, 1, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1); // tracker cleared

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall0}, 0);
    chk("rst_exv", {31'd0, exv0}, 0);
    chk("rst_sel", {28'd0, sel0}, 0);
    chk("rst_cnt", {16'd0, cnt0}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].s1, tbl[i].s0, tbl[i].used, tbl[i].dst,
            tbl[i].wr, tbl[i].ld, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall0}, {31'd0, tbl[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_exv", i), {31'd0, exv0}, {31'd0, tbl[i].e_exv});
      if (tbl[i].chk_sel)
        chk($sformatf("vec%0d_sel", i), {28'd0, sel0}, {28'd0, tbl[i].e_sel1, tbl[i].e_sel0});
      chk($sformatf("vec%0d_cnt", i), {16'd0, cnt0}, {16'd0, tbl[i].e_cnt});
      $display("vec %0d stall=%0b ex_valid=%0b ex_fwd_sel=%0h stall_cnt=%0d",
               i, tbl[i].e_stall, exv0, sel0, cnt0);
      @(negedge clk);
    end

    // Register 0: u0 forwards it, u1 treats it as hardwired.
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("r0_sel_soft", {28'd0, sel0}, 32'd1);
    chk("r0_sel_hard", {28'd0, sel1}, 32'd0);
    $display("r0 write: soft sel=%0h hard sel=%0h", sel0, sel1);
    @(negedge clk);

    // Long load-use run on the deep instance.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 2, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("long%0d_stall", i), {31'd0, stall2}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("long%0d_cnt", i), {28'd0, cnt2}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      $display("long stall %0d stall_cnt=%0d", i, cnt2);
      @(negedge clk);
    end
    #1;
    chk("long_release_stall", {31'd0, stall2}, 32'd0);
    @(posedge clk);
    #1;
    chk("long_release_sel", {27'd0, sel2[4:0]}, 32'd21);
    chk("long_release_exv", {31'd0, exv2}, 32'd1);
    chk("long_sat_cnt", {28'd0, cnt2}, 32'd15);
    $display("long release sel=%0d stall_cnt=%0d", sel2[4:0], cnt2);
    @(negedge clk);

    // Reset asserted mid-stall.
    drive(1, 0, 0, 0, 2, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 2, 1, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("pre_rst_stall", {31'd0, stall2}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", {31'd0, stall2}, 32'd0);
    chk("async_rst_exv", {31'd0, exv2}, 32'd0);
    chk("async_rst_sel", {22'd0, sel2}, 32'd0);
    chk("async_rst_cnt", {28'd0, cnt2}, 32'd0);
    chk("async_rst_cnt_u0", {16'd0, cnt0}, 32'd0);
    chk("async_rst_exv_u0", {31'd0, exv0}, 32'd0);
    $display("async reset: stall=%0b ex_valid=%0b sel=%0h cnt=%0d", stall2, exv2, sel2, cnt2);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, stall2}, 32'd0);
    chk("post_rst_stall_u0", {31'd0, stall0}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_exv", {31'd0, exv2}, 32'd1);
    chk("post_rst_sel", {22'd0, sel2}, 32'd0);
    chk("post_rst_cnt", {28'd0, cnt2}, 32'd0);
    $display("after reset: ex_valid=%0b sel=%0h cnt=%0d", exv2, sel2, cnt2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- REG_AW, 3, register address width.
- DEPTH, 3, number of in-flight producer stages tracked (T[0] = EX … T[DEPTH-1]).
- NUM_SRC, 2, source operands per instruction.
- LOAD_STG, 2, first stage index (1..DEPTH) whose output carries load data.
- ZERO_HARD, 0, 1 = register 0 is hardwired and never matches.
- CNT_W, 16, stall counter width.
- SELW = clog2(DEPTH+1), derived.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_src_addr, in, NUM_SRC*REG_AW, source register addresses, src i at bits [i*REG_AW +: REG_AW].
- id_src_used, in, NUM_SRC, per-source "operand is read" flag.
- id_dst_addr, in, REG_AW, destination register.
- id_dst_wr, in, 1, instruction writes id_dst_addr.
- id_is_load, in, 1, instruction is a memory read.
- flush, in, 1, squash all in-flight instructions and ID.
- stall, out, 1, hold PC/IF/ID this cycle.
- ex_valid, out, 1, EX holds a real instruction.
- ex_fwd_sel, out, NUM_SRC*SELW, per-source bypass select for the instruction now in EX.
- stall_cnt, out, CNT_W, saturating count of load-use stall cycles.

Function
REQ-003 Each tracker entry T[k] SHALL hold {v, wr, ld, dst}, registered.
REQ-004 When stall=0, each rising edge SHALL shift T[k] -> T[k+1] and drop T[DEPTH-1]; T[0] SHALL load {id_valid, id_dst_wr, id_is_load, id_dst_addr}.
REQ-005 When stall=1, the tracker SHALL still shift, and T[0] SHALL load a bubble (v=0).
REQ-006 Source i SHALL match T[k] iff id_src_used[i] & T[k].v & T[k].wr & T[k].dst==src_i, and also (ZERO_HARD=0 | src_i!=0).
REQ-007 For each source, the lowest matching k (youngest producer) SHALL win; older matches SHALL be ignored.
REQ-008 Forward select SHALL be sel_i = k+1 when matched, else 0 (register file); value k+1 names the output of the stage the producer occupies when the consumer reaches EX.
REQ-009 Load-use: stall SHALL be 1 iff id_valid & !flush & some source's winning match has T[k].ld=1 and k+1 < LOAD_STG; it is combinational from tracker state and ID inputs.
REQ-010 When stall=0 and flush=0, ex_valid and ex_fwd_sel SHALL register id_valid and the computed sel_i; when stall=1 they SHALL register 0 (bubble).
REQ-011 flush=1 SHALL force stall=0 and clear every T[k].v, ex_valid and ex_fwd_sel at the next edge; flush has priority over stall and shift.
REQ-012 stall_cnt SHALL increment by 1 on each edge where stall=1, saturating at 2^CNT_W-1 with no wrap; flush does not clear it.
REQ-013 Arithmetic width: sel fields SHALL be SELW bits wide; matches beyond DEPTH stages SHALL read 0 (register file supplies the value).
REQ-014 With id_valid=0, stall SHALL be 0 and a bubble SHALL enter T[0].

Reset
REQ-015 rst_n=0 SHALL asynchronously clear all T[k] fields, ex_valid, ex_fwd_sel and stall_cnt to 0; stall SHALL read 0 while reset is held.
REQ-016 Reset asserted mid-stall SHALL discard the pending stall; the first cycle after release behaves as an empty pipeline.

Verification
REQ-017 Defaults: ADD r1 issued in cycle 0; cycle 1 ID reads src0=r1 -> stall=0, ex_fwd_sel src0=1 after the edge.
REQ-018 LD r2 in cycle 0; cycle 1 ID uses src1=r2 -> stall=1 for exactly one cycle, ex_valid=0 next; cycle 2 -> stall=0, src1 sel=2, stall_cnt=1.
REQ-019 r3 written in T[0] and T[1], consumer reads r3 on both sources -> both sels=1; with id_src_used=2'b01 -> src1 sel=0.
REQ-020 Flush during a load-use stall -> stall=0 that cycle, all T[k].v, ex_valid and ex_fwd_sel = 0 next edge; ZERO_HARD=1 with a write to r0 -> sel=0.
REQ-021 CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds 15; rst_n pulsed low mid-stall -> all outputs 0 immediately, no clock edge needed.
